mdu_ctrl: RTL and testbench

//   Multi-cycle multiply/divide unit controller with HI/LO registers, sitting beside the E-stage ALU.
//   - Accepts one MDU operation per start pulse from the E stage.
//   - Holds busy for a fixed per-op latency, then commits the result to HI/LO.
//   - Raises a stall request while a D-stage MDU instruction must wait.

---
 rtl/mdu_ctrl.sv | 129 ++++++++++++
 tb/tb_mdu_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers.
// Result is computed at issue, held in shadow regs, committed after a fixed latency.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mdu_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [31:0]   shadow_hi;
    logic [31:0]   shadow_lo;
    logic          shadow_ok;

    logic          mc_start;
    logic          is_div;
    logic          sgn;
    logic [63:0]   a_ext;
    logic [63:0]   b_ext;
    logic [63:0]   prod;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   divisor;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    assign mc_start = start & ~op[2];
    assign is_div   = op[1];
    assign sgn      = ~op[0];

    always_comb begin
        a_ext   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        prod    = a_ext * b_ext;
        a_neg   = sgn & a[31];
        b_neg   = sgn & b[31];
        a_mag   = a_neg ? (~a + 32'd1) : a;
        b_mag   = b_neg ? (~b + 32'd1) : b;
        // divisor forced nonzero; a zero-divide result is never committed
        divisor = (b == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        if (is_div) begin
            res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        end else begin
            res_lo = prod[31:0];
            res_hi = prod[63:32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (mc_start) state_nx = BUSY;
            BUSY:    if (count == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            shadow_ok <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mc_start) begin
                        shadow_hi <= res_hi;
                        shadow_lo <= res_lo;
                        shadow_ok <= ~(is_div & (b == 32'd0));
                        count     <= is_div ? CW'(DIV_CYCLES - 1)
                                            : CW'(MULT_CYCLES - 1);
                    end else if (start && op == 3'd4) begin
                        hi <= a;
                    end else if (start && op == 3'd5) begin
                        lo <= a;
                    end
                end
                BUSY: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else if (shadow_ok) begin
                        hi <= shadow_hi;
                        lo <= shadow_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == BUSY);
    assign stall = mdu_use_d & (busy | mc_start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized bench for mdu_ctrl against a timestamp-based HI/LO model.
// Directed literal checks pin the model on the documented cases.
module tb_mdu_ctrl;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mdu_use_d = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .mdu_use_d (mdu_use_d),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] rh,
                                   output logic [31:0] rl, output bit ok);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        rh = 32'd0;
        rl = 32'd0;
        ok = 1'b1;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {rh, rl} = sp;
            end
            3'd1: begin
                up = {32'b0, x} * {32'b0, y};
                {rh, rl} = up;
            end
            3'd2: begin
                if (y == 32'd0) ok = 1'b0;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000;
                    rh = 32'd0;
                end else begin
                    q  = $signed(x) / $signed(y);
                    r  = $signed(x) % $signed(y);
                    rl = q;
                    rh = r;
                end
            end
            default: begin
                if (y == 32'd0) ok = 1'b0;
                else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endfunction

    // model: an accepted op finishes at edge (issue edge + latency)
    bit          m_act = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_ok = 1'b0;
    longint      edge_n = 0;
    longint      done_edge = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act = 1'b0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
        end else begin
            edge_n++;
            if (m_act) begin
                if (edge_n == done_edge) begin
                    if (p_ok) begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                    end
                    m_act = 1'b0;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    ref_op(op, a, b, p_hi, p_lo, p_ok);
                    m_act     = 1'b1;
                    done_edge = edge_n + ((op <= 3'd1) ? NM : ND);
                end else if (op == 3'd4) begin
                    m_hi = a;
                end else if (op == 3'd5) begin
                    m_lo = a;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("busy", {31'b0, busy}, {31'b0, m_act});
        chk("stall", {31'b0, stall},
            {31'b0, mdu_use_d & (m_act | (start & (op <= 3'd3)))});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    task automatic cyc(input bit st, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit u);
        @(negedge clk);
        start     = st;
        op        = o;
        a         = x;
        b         = y;
        mdu_use_d = u;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        start     = 1'b0;
        mdu_use_d = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #2 reset = 1'b1;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset = 1'b0;
        idle(2);
        #6 reset = 1'b1;
        idle(1);
        #2;
        chk("init_busy", {31'b0, busy}, 32'd0);
        chk("init_hi", hi, 32'd0);

        cyc(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd4, 1'b0);
        idle(NM + 1);
        #2;
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF4);

        cyc(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd4, 1'b0);
        idle(NM + 1);
        #2;
        chk("multu_hi", hi, 32'h0000_0003);
        chk("multu_lo", lo, 32'hFFFF_FFF4);

        cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(ND + 1);
        #2;
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        cyc(1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
        idle(ND + 1);
        #2;
        chk("divu_hi", hi, 32'd1);
        chk("divu_lo", lo, 32'd3);

        cyc(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(ND + 1);
        #2;
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);

        cyc(1'b1, 3'd4, 32'h11, 32'd0, 1'b0);
        cyc(1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
        cyc(1'b1, 3'd3, 32'd5, 32'd0, 1'b0);
        idle(ND);
        #2;
        chk("div0_busy_last", {31'b0, busy}, 32'd1);
        idle(1);
        #2;
        chk("div0_busy", {31'b0, busy}, 32'd0);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        cyc(1'b1, 3'd0, 32'd3, 32'd5, 1'b1);
        #2;
        chk("stall_start", {31'b0, stall}, 32'd1);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cyc(1'b1, 3'd5, 32'h55, 32'd0, 1'b1);
        #2;
        chk("stall_busy", {31'b0, stall}, 32'd1);
        repeat (NM - 1) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        #2;
        chk("stall_after", {31'b0, stall}, 32'd0);
        chk("mtlo_ign_lo", lo, 32'd15);
        chk("mtlo_ign_hi", hi, 32'd0);

        cyc(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        #2;
        chk("mthi_stall", {31'b0, stall}, 32'd0);
        cyc(1'b1, 3'd7, 32'h1234, 32'd0, 1'b1);
        #2;
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("nop_stall", {31'b0, stall}, 32'd0);

        cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        rst_pulse();
        idle(ND + 2);
        #2;
        chk("norecommit_hi", hi, 32'd0);
        chk("norecommit_lo", lo, 32'd0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(199) == 0) begin
                rst_pulse();
            end else begin
                cyc($urandom_range(2) == 0, 3'($urandom_range(7)),
                    rnd32(), rnd32(), $urandom_range(1) == 1);
            end
        end
        idle(ND + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
